// File: rtl/out_fifo_gen.sv
// Single-clock output FIFO: stores NUM_CH-channel words and replays each as RATIO narrower read beats.
// Optional sticky OVERFLOW/UNDERFLOW outputs are built when OUT_FIFO_GEN_ERR_FLAGS_EN is defined.
module out_fifo_gen #(
    parameter int NUM_CH             = 10,
    parameter int OUT_W              = 4,
    parameter int RATIO              = 2,
    parameter int DEPTH              = 8,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           WREN,
    input  logic [NUM_CH*OUT_W*RATIO-1:0]  D,
    input  logic                           RDEN,
    output logic [NUM_CH*OUT_W-1:0]        Q,
    output logic                           EMPTY,
    output logic                           ALMOSTEMPTY,
    output logic                           FULL,
    output logic                           ALMOSTFULL
`ifdef OUT_FIFO_GEN_ERR_FLAGS_EN
    ,
    output logic                           OVERFLOW,
    output logic                           UNDERFLOW
`endif
);

    localparam int DW    = NUM_CH * OUT_W * RATIO;
    localparam int QW    = NUM_CH * OUT_W;
    localparam int CH_W  = OUT_W * RATIO;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_VALUE);
    localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_VALUE);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH);
    localparam bit            SINGLE  = (RATIO == 1);

    generate
        if (NUM_CH < 1 || OUT_W < 1 || !(RATIO == 1 || RATIO == 2) ||
            DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
            ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH / 2 ||
            ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH / 2) begin : g_param_err
            $fatal(1, "out_fifo_gen: illegal parameter value");
        end
    endgenerate

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          phase_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          empty_reg, aempty_reg, full_reg, afull_reg;
    logic [QW-1:0] q_reg, beat_next;
    logic [DW-1:0] rd_word;
    logic          wr_acc, rd_acc, pop;

    // Acceptance is judged on the registered flags, so a pop cannot rescue a write at FULL.
    assign wr_acc  = WREN && !full_reg;
    assign rd_acc  = RDEN && !empty_reg;
    assign pop     = rd_acc && (SINGLE || phase_reg);
    assign rd_word = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !wr_acc)
            count_next = count_reg - CW'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_beat
            if (RATIO == 2) begin : g_half
                assign beat_next[gi*OUT_W +: OUT_W] = phase_reg ? rd_word[gi*CH_W + OUT_W +: OUT_W]
                                                                : rd_word[gi*CH_W +: OUT_W];
            end else begin : g_full
                assign beat_next[gi*OUT_W +: OUT_W] = rd_word[gi*CH_W +: OUT_W];
            end
        end
    endgenerate

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_acc)
            mem[wr_ptr_reg] <= D;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            phase_reg  <= 1'b0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            aempty_reg <= 1'b1;
            full_reg   <= 1'b0;
            afull_reg  <= 1'b0;
            q_reg      <= '0;
        end else begin
            if (wr_acc)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_acc) begin
                q_reg <= beat_next;
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    phase_reg  <= 1'b0;
                end else begin
                    phase_reg  <= 1'b1;
                end
            end
            count_reg  <= count_next;
            empty_reg  <= (count_next == '0);
            aempty_reg <= (count_next <= AE_TH);
            full_reg   <= (count_next == FULL_TH);
            afull_reg  <= (count_next >= AF_TH);
        end
    end

    assign Q           = q_reg;
    assign EMPTY       = empty_reg;
    assign ALMOSTEMPTY = aempty_reg;
    assign FULL        = full_reg;
    assign ALMOSTFULL  = afull_reg;

`ifdef OUT_FIFO_GEN_ERR_FLAGS_EN
    logic overflow_reg, underflow_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (WREN && full_reg)
                overflow_reg <= 1'b1;
            if (RDEN && empty_reg)
                underflow_reg <= 1'b1;
        end
    end

    assign OVERFLOW  = overflow_reg;
    assign UNDERFLOW = underflow_reg;
`endif

endmodule
